// File: rtl/mem_block_copy.sv
// rtl/mem_block_copy.sv - bus-initiator word copier with one-cycle read latency cover
// Copies len words from src to dst over the shared mem_cmd/mem_addr bus, ascending order.
module mem_block_copy #(
  parameter int addr_width = 9,
  parameter int data_width = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [addr_width-1:0] src_addr,
  input  logic [addr_width-1:0] dst_addr,
  input  logic [addr_width-1:0] len,
  output logic [1:0]            mem_cmd,
  output logic [addr_width-1:0] mem_addr,
  input  logic [data_width-1:0] read_data,
  output logic [data_width-1:0] write_data,
  output logic                  busy,
  output logic                  done,
  output logic [addr_width-1:0] remaining
);

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;
  localparam logic [addr_width-1:0] ONE = addr_width'(1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR, DONE} state_t;

  state_t                state, state_nxt;
  logic [addr_width-1:0] src_q, dst_q, i_q, rem_q;
  logic [data_width-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      i_q    <= '0;
      rem_q  <= '0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            i_q   <= '0;
            rem_q <= len;
          end
        end
        // RAM dout is valid during the second MREAD cycle
        RD_WAIT: data_q <= read_data;
        WR: begin
          i_q   <= i_q + ONE;
          rem_q <= rem_q - ONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    mem_cmd   = MNONE;
    mem_addr  = '0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (len == '0) ? DONE : RD_REQ;
      end
      RD_REQ: begin
        mem_cmd   = MREAD;
        mem_addr  = src_q + i_q;
        state_nxt = RD_WAIT;
      end
      // Responder enables decode mem_cmd/mem_addr, so both stay held here
      RD_WAIT: begin
        mem_cmd   = MREAD;
        mem_addr  = src_q + i_q;
        state_nxt = WR;
      end
      WR: begin
        mem_cmd   = MWRITE;
        mem_addr  = dst_q + i_q;
        state_nxt = (rem_q == ONE) ? DONE : RD_REQ;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign write_data = data_q;
  assign remaining  = rem_q;

endmodule

// File: tb/tb_mem_block_copy.sv
// tb/tb_mem_block_copy.sv - directed bench for mem_block_copy with RAM, switch and LED responders
module tb_mem_block_copy;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  src_addr = '0, dst_addr = '0, len = '0;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] read_data, write_data;
  logic        busy, done;
  logic [8:0]  remaining;

  mem_block_copy #(.addr_width(9), .data_width(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .read_data(read_data),
    .write_data(write_data), .busy(busy), .done(done), .remaining(remaining)
  );

  always #5 clk = ~clk;

  // Responders: sync RAM, LED register at 0x100, switches at 0x140
  logic [15:0] ram [0:511];
  logic [15:0] ram_q = '0;
  logic [7:0]  led = '0;
  logic [7:0]  sw = '0;

  always @(posedge clk) begin
    if (mem_cmd == 2'b01) ram_q <= ram[mem_addr];
    if (mem_cmd == 2'b10) begin
      if (mem_addr == 9'h100) led <= write_data[7:0];
      else ram[mem_addr] <= write_data;
    end
  end

  assign read_data = (mem_cmd == 2'b01 && mem_addr == 9'h140) ? {8'h00, sw} : ram_q;

  // Bus log
  logic [8:0]  rq [$];
  logic [8:0]  wa [$];
  logic [15:0] wd [$];
  int          dcount = 0;

  always @(negedge clk) begin
    if (mem_cmd == 2'b01) rq.push_back(mem_addr);
    if (mem_cmd == 2'b10) begin
      wa.push_back(mem_addr);
      wd.push_back(write_data);
    end
    if (done) dcount++;
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_copy(input logic [8:0] s, input logic [8:0] d, input logic [8:0] n,
                          output int cyc);
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  int cyc, r0, w0, d0;

  initial begin
    for (int k = 0; k < 512; k++) ram[k] = 16'h0000;
    #1;
    chk("rst_cmd", mem_cmd, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rem", remaining, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_addr", mem_addr, 0);
    tick();
    reset = 1'b0;
    tick();

    // Basic copy
    ram[9'h010] = 16'hAAAA; ram[9'h011] = 16'h5555; ram[9'h012] = 16'h1234;
    run_copy(9'h010, 9'h020, 9'd3, cyc);
    chk("basic_lat", cyc, 10);
    chk("basic_busy", busy, 1);
    chk("basic_rem", remaining, 0);
    chk("basic_w0", ram[9'h020], 16'hAAAA);
    chk("basic_w1", ram[9'h021], 16'h5555);
    chk("basic_w2", ram[9'h022], 16'h1234);
    tick();
    chk("basic_idle", busy, 0);

    // Zero length
    ram[9'h040] = 16'h7777;
    r0 = rq.size(); w0 = wq_size();
    run_copy(9'h030, 9'h040, 9'd0, cyc);
    chk("zero_lat", cyc, 1);
    chk("zero_cmd", mem_cmd, 2'b00);
    tick();
    chk("zero_reads", rq.size() - r0, 0);
    chk("zero_writes", wq_size() - w0, 0);
    chk("zero_ram", ram[9'h040], 16'h7777);

    // Address wrap-around
    ram[9'h1FF] = 16'hBEEF; ram[9'h000] = 16'hCAFE;
    r0 = rq.size(); w0 = wq_size();
    run_copy(9'h1FF, 9'h0F0, 9'd2, cyc);
    chk("wrap_lat", cyc, 7);
    chk("wrap_nrd", rq.size() - r0, 4);
    chk("wrap_rd0", rq[r0], 9'h1FF);
    chk("wrap_rd1", rq[r0+2], 9'h000);
    chk("wrap_wa0", wa[w0], 9'h0F0);
    chk("wrap_wa1", wa[w0+1], 9'h0F1);
    chk("wrap_d0", ram[9'h0F0], 16'hBEEF);
    chk("wrap_d1", ram[9'h0F1], 16'hCAFE);
    tick();

    // Switch to LED
    sw = 8'h5A;
    w0 = wq_size();
    run_copy(9'h140, 9'h100, 9'd1, cyc);
    chk("io_lat", cyc, 4);
    chk("io_wa", wa[w0], 9'h100);
    chk("io_wd", wd[w0], 16'h005A);
    chk("io_led", led, 8'h5A);
    tick();

    // Reset during the second word's RD_WAIT
    for (int k = 0; k < 4; k++) begin
      ram[9'h050 + k] = 16'(k + 1);
      ram[9'h060 + k] = 16'hEEEE;
    end
    src_addr = 9'h050; dst_addr = 9'h060; len = 9'd4; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("mid_cmd_pre", mem_cmd, 2'b01);
    chk("mid_addr_pre", mem_addr, 9'h051);
    reset = 1'b1;
    #1;
    chk("mid_cmd", mem_cmd, 2'b00);
    chk("mid_busy", busy, 0);
    chk("mid_rem", remaining, 0);
    chk("mid_addr", mem_addr, 0);
    chk("mid_wdata", write_data, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("mid_w0", ram[9'h060], 16'h0001);
    chk("mid_w1", ram[9'h061], 16'hEEEE);
    chk("mid_w3", ram[9'h063], 16'hEEEE);
    run_copy(9'h050, 9'h060, 9'd4, cyc);
    chk("mid_relat", cyc, 13);
    chk("mid_re_w1", ram[9'h061], 16'h0002);
    chk("mid_re_w3", ram[9'h063], 16'h0004);
    tick();

    // Start while busy is ignored
    ram[9'h070] = 16'h1111; ram[9'h071] = 16'h2222;
    ram[9'h090] = 16'h9999;
    d0 = dcount;
    src_addr = 9'h070; dst_addr = 9'h080; len = 9'd2; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    tick(); cyc++;
    chk("ign_busy", busy, 1);
    src_addr = 9'h072; dst_addr = 9'h090; len = 9'd5; start = 1'b1;
    tick(); cyc++;
    start = 1'b0;
    while (done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("ign_lat", cyc, 7);
    repeat (4) tick();
    chk("ign_dones", dcount - d0, 1);
    chk("ign_w0", ram[9'h080], 16'h1111);
    chk("ign_w1", ram[9'h081], 16'h2222);
    chk("ign_other", ram[9'h090], 16'h9999);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  function automatic int wq_size();
    return wa.size();
  endfunction

endmodule
